// File: rtl/mont_pkg.sv
// ---------------------------------------------------------------------------
// mont_pkg
// Shared definitions for the sequenced Montgomery multiplier and its helpers:
//   - mont_state_e    : controller states (IDLE, RUN, CSUB, DONE)
//   - MONT_WID_DEFAULT: default operand/modulus width
//   - clog2()         : counter width for a given iteration count
// ---------------------------------------------------------------------------
package mont_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CSUB = 2'd2,
        DONE = 2'd3
    } mont_state_e;

    localparam int MONT_WID_DEFAULT = 256;

    // Ceiling log2; clog2(2) = 1 so a 2-bit datapath still gets a 1-bit counter.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mont_csub.sv
// ---------------------------------------------------------------------------
// mont_csub
// Combinational conditional subtractor: res = (acc >= m) ? acc - m : acc,
// returned as WID bits. Shared with the modular-add block.
// Ports:
//   acc [WID:0]   : value to reduce, expected < 2m
//   m   [WID-1:0] : modulus
//   res [WID-1:0] : reduced value
// ---------------------------------------------------------------------------
module mont_csub
    import mont_pkg::*;
#(
    parameter int WID = MONT_WID_DEFAULT
) (
    input  logic [WID:0]   acc,
    input  logic [WID-1:0] m,
    output logic [WID-1:0] res
);

    logic           ge;
    logic [WID-1:0] diff_lo;

    always_comb begin
        ge = (acc >= {1'b0, m});
        // Only the low WID bits of acc - m are needed: when acc >= m the
        // difference is below m and therefore fits in WID bits.
        diff_lo = acc[WID-1:0] - m;
        res     = ge ? diff_lo : acc[WID-1:0];
    end

endmodule

// File: rtl/mont_mul_seq.sv
// ---------------------------------------------------------------------------
// mont_mul_seq
// Bit-serial radix-2 Montgomery multiplier, r = a*b*2^-WID mod m, fully
// reduced. One multiplier bit is consumed per RUN cycle, followed by a single
// conditional-subtract cycle. Handshake at the front and back end.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_vld / in_rdy   : request handshake; a, b, m sampled on in_vld & in_rdy
//   a, b  [WID-1:0]   : operands (a, b < m)
//   m     [WID-1:0]   : odd modulus
//   out_vld / out_rdy : result handshake; r held while out_vld & !out_rdy
//   r     [WID-1:0]   : registered result, 0 <= r < m
// ---------------------------------------------------------------------------
module mont_mul_seq
    import mont_pkg::*;
#(
    parameter int WID = MONT_WID_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    input  logic [WID-1:0] m,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [WID-1:0] r
);

    localparam int                CNT_W    = clog2(WID);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WID - 1);

    mont_state_e      state_q, state_d;
    logic [WID-1:0]   as_q, as_d;
    logic [WID-1:0]   b_q, b_d;
    logic [WID-1:0]   m_q, m_d;
    logic [WID:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WID-1:0]   r_q, r_d;
    logic             in_rdy_q, in_rdy_d;
    logic             out_vld_q, out_vld_d;

    logic [WID+1:0]   s1;
    logic [WID-1:0]   csub_res;

    mont_csub #(.WID(WID)) u_csub (
        .acc (acc_q),
        .m   (m_q),
        .res (csub_res)
    );

    always_comb begin
        state_d = state_q;
        as_d    = as_q;
        b_d     = b_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        r_d     = r_q;

        s1 = {1'b0, acc_q} + (as_q[0] ? {2'b00, b_q} : '0);

        case (state_q)
            IDLE: begin
                if (in_vld && in_rdy_q) begin
                    as_d    = a;
                    b_d     = b;
                    m_d     = m;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Adding m when s1 is odd makes the sum even so the halving
                // is exact. The sum's MSB after the shift is always 0 because
                // the accumulator stays below 2m, so WID+1 bits suffice.
                acc_d = (WID+1)'((s1 + (s1[0] ? {2'b00, m_q} : '0)) >> 1);
                as_d  = as_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = CSUB;
                end
            end
            CSUB: begin
                r_d     = csub_res;
                state_d = DONE;
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next state, so a
        // DONE->IDLE transition only opens the input one cycle later.
        in_rdy_d  = (state_d == IDLE);
        out_vld_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            as_q      <= '0;
            b_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            r_q       <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            as_q      <= as_d;
            b_q       <= b_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_vld = out_vld_q;
    assign r       = r_q;

endmodule

// File: tb/tb_mont_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_mont_mul_seq
// Bench for mont_mul_seq: an 8-bit instance for directed protocol steps and a
// 256-bit instance for random operands. Expected results come from modular
// arithmetic on wide integers: (a*b mod m) times the inverse of 2^WID mod m.
// ---------------------------------------------------------------------------
module tb_mont_mul_seq;

    localparam int W_S = 8;
    localparam int W_L = 256;
    localparam logic [255:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           s_in_vld, s_in_rdy, s_out_vld, s_out_rdy;
    logic [W_S-1:0] s_a, s_b, s_m, s_r;
    logic           l_in_vld, l_in_rdy, l_out_vld, l_out_rdy;
    logic [W_L-1:0] l_a, l_b, l_m, l_r;

    mont_mul_seq #(.WID(W_S)) dut_s (
        .clk(clk), .rst(rst),
        .in_vld(s_in_vld), .in_rdy(s_in_rdy),
        .a(s_a), .b(s_b), .m(s_m),
        .out_vld(s_out_vld), .out_rdy(s_out_rdy), .r(s_r)
    );

    mont_mul_seq #(.WID(W_L)) dut_l (
        .clk(clk), .rst(rst),
        .in_vld(l_in_vld), .in_rdy(l_in_rdy),
        .a(l_a), .b(l_b), .m(l_m),
        .out_vld(l_out_vld), .out_rdy(l_out_rdy), .r(l_r)
    );

    int tests  = 0;
    int failed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // a*b*2^-w mod m: reduce the product, then multiply w times by 2^-1 mod m,
    // which is (m+1)/2 for odd m.
    function automatic logic [255:0] ref_mont(input logic [255:0] av, input logic [255:0] bv,
                                              input logic [255:0] mv, input int w);
        logic [511:0] mm, x, h, inv;
        mm  = {256'd0, mv};
        x   = ({256'd0, av} * {256'd0, bv}) % mm;
        h   = (mm + 512'd1) >> 1;
        inv = 512'd1;
        for (int i = 0; i < w; i++) inv = (inv * h) % mm;
        x = (x * inv) % mm;
        return x[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Counts cycles from the first cycle after acceptance until out_vld,
    // noting whether in_rdy was ever seen high in between.
    task automatic wait_out(input bit big, output int lat, output bit rdy_seen);
        lat      = 1;
        rdy_seen = 1'b0;
        while (!(big ? l_out_vld : s_out_vld) && lat < (big ? W_L : W_S) + 20) begin
            if (big ? l_in_rdy : s_in_rdy) rdy_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    // One complete request with out_rdy held high.
    task automatic run_op(input bit big, input logic [255:0] av, input logic [255:0] bv,
                          input logic [255:0] mv, input string tag);
        int           lat;
        bit           rdy_seen;
        logic [255:0] ev;
        int           w;
        w  = big ? W_L : W_S;
        ev = ref_mont(av, bv, mv, w);
        if (big) begin
            l_a = av; l_b = bv; l_m = mv; l_in_vld = 1'b1;
        end else begin
            s_a = av[7:0]; s_b = bv[7:0]; s_m = mv[7:0]; s_in_vld = 1'b1;
        end
        chk({tag, " in_rdy"}, 256'(big ? l_in_rdy : s_in_rdy), 256'd1);
        tick();
        // Operand changes after acceptance must not disturb the computation.
        l_in_vld = 1'b0; s_in_vld = 1'b0;
        l_a = rand256(); l_b = rand256(); l_m = rand256();
        s_a = 8'($urandom); s_b = 8'($urandom); s_m = 8'($urandom);
        wait_out(big, lat, rdy_seen);
        chk({tag, " latency"}, 256'(lat), 256'(w + 2));
        chk({tag, " in_rdy busy"}, 256'(rdy_seen), 256'd0);
        chk({tag, " r"}, big ? l_r : {248'd0, s_r}, ev);
        tick();
        chk({tag, " idle in_rdy"}, 256'(big ? l_in_rdy : s_in_rdy), 256'd1);
        chk({tag, " idle out_vld"}, 256'(big ? l_out_vld : s_out_vld), 256'd0);
    endtask

    initial begin
        int           lat;
        int           n;
        bit           rdy_seen;
        bit           seen;
        logic [7:0]   r1;
        logic [255:0] ma, aa, ba;
        logic [7:0]   ms;

        rst = 1'b1;
        s_in_vld = 1'b0; s_out_rdy = 1'b1; s_a = '0; s_b = '0; s_m = 8'd13;
        l_in_vld = 1'b0; l_out_rdy = 1'b1; l_a = '0; l_b = '0; l_m = '0;

        // Reset state
        tick(); tick();
        chk("rst in_rdy", 256'(s_in_rdy), 256'd0);
        chk("rst out_vld", 256'(s_out_vld), 256'd0);
        chk("rst r", {248'd0, s_r}, 256'd0);
        chk("rst l in_rdy", 256'(l_in_rdy), 256'd0);
        rst = 1'b0;
        tick();
        chk("post rst in_rdy", 256'(s_in_rdy), 256'd1);
        chk("post rst l in_rdy", 256'(l_in_rdy), 256'd1);

        // Directed values, m = 13
        run_op(1'b0, 256'd5,  256'd7,  256'd13, "a5b7");
        run_op(1'b0, 256'd9,  256'd9,  256'd13, "a9b9");
        run_op(1'b0, 256'd0,  256'd12, 256'd13, "a0b12");
        run_op(1'b0, 256'd12, 256'd12, 256'd13, "a12b12");
        chk("const a5b7", ref_mont(256'd5, 256'd7, 256'd13, 8), 256'd1);

        // Back-pressure: result held for 15 cycles, in_vld ignored
        s_out_rdy = 1'b0;
        s_a = 8'd1; s_b = 8'd1; s_m = 8'd13; s_in_vld = 1'b1;
        tick();
        s_in_vld = 1'b0;
        wait_out(1'b0, lat, rdy_seen);
        chk("bp latency", 256'(lat), 256'd10);
        for (int i = 0; i < 15; i++) begin
            s_in_vld = i[0];
            s_a = 8'($urandom_range(0, 12)); s_b = 8'($urandom_range(0, 12));
            chk("bp r", {248'd0, s_r}, 256'd3);
            chk("bp out_vld", 256'(s_out_vld), 256'd1);
            chk("bp in_rdy", 256'(s_in_rdy), 256'd0);
            tick();
        end
        s_in_vld = 1'b0; s_m = 8'd13; s_out_rdy = 1'b1;
        chk("bp r final", {248'd0, s_r}, 256'd3);
        tick();
        chk("bp release in_rdy", 256'(s_in_rdy), 256'd1);
        chk("bp release out_vld", 256'(s_out_vld), 256'd0);

        // Reset in the middle of RUN
        s_a = 8'd5; s_b = 8'd7; s_m = 8'd13; s_in_vld = 1'b1;
        tick();
        s_in_vld = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("midrst in_rdy", 256'(s_in_rdy), 256'd0);
        chk("midrst out_vld", 256'(s_out_vld), 256'd0);
        rst = 1'b0;
        tick();
        chk("midrst after in_rdy", 256'(s_in_rdy), 256'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (s_out_vld) seen = 1'b1;
            tick();
        end
        chk("midrst no out_vld", 256'(seen), 256'd0);
        run_op(1'b0, 256'd5, 256'd7, 256'd13, "after_rst");

        // Back-to-back with out_rdy high and in_vld held
        s_out_rdy = 1'b1;
        s_a = 8'd5; s_b = 8'd7; s_m = 8'd13; s_in_vld = 1'b1;
        tick();
        s_a = 8'd12; s_b = 8'd12;
        n = 1; r1 = 8'hFF; seen = 1'b0;
        while (!s_in_rdy && n < 40) begin
            if (s_out_vld) begin
                r1 = s_r; seen = 1'b1;
            end
            tick();
            n++;
        end
        chk("b2b interval", 256'(n), 256'd11);
        chk("b2b first seen", 256'(seen), 256'd1);
        chk("b2b first r", {248'd0, r1}, 256'd1);
        tick();
        s_in_vld = 1'b0;
        wait_out(1'b0, lat, rdy_seen);
        chk("b2b second latency", 256'(lat), 256'd10);
        chk("b2b second r", {248'd0, s_r}, 256'd3);
        tick();

        // Small-width random operands with random odd moduli
        for (int k = 0; k < 20; k++) begin
            ms = 8'($urandom_range(3, 255)) | 8'd1;
            run_op(1'b0, 256'(8'($urandom_range(0, 255)) % ms),
                   256'(8'($urandom_range(0, 255)) % ms), 256'(ms), "rnd8");
        end

        // 256-bit random operands, including the P-256 prime
        for (int k = 0; k < 150; k++) begin
            if (k == 0 || k % 10 == 3) begin
                ma = P256;
            end else if (k % 5 == 1) begin
                ma = {224'd0, 32'($urandom)} | 256'd1;
            end else begin
                ma = rand256() | 256'd1;
            end
            if (ma < 256'd3) ma = 256'd3;
            if (k == 0) begin
                aa = ma - 256'd1; ba = ma - 256'd1;
            end else begin
                aa = rand256() % ma; ba = rand256() % ma;
            end
            run_op(1'b1, aa, ba, ma, "rnd256");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
